// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM state
// encoding, opcode constants and the ALUOp / ALUControl encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRLINK = 4'd12,
    ILLEGAL  = 4'd13
  } statetype;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl: single-cycle ALU encoding
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Multiplexer select encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Extend-unit select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALUOp plus instruction fields onto the
// single-cycle ALUControl encoding.
module aludec
  import riscv_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // Pure combinational decode; register-register subtract only when op[5] set
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch/decode/execute,
// ImmSrc decode, and the ALU decoder instance.
module mc_controller
  import riscv_pkg::*;
#(
  parameter bit HAS_JALR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Retire,
  output logic       Illegal
);

  statetype   state, next_state;
  logic       pc_update, branch;
  logic       ir_write_s, mem_write_s, reg_write_s, retire_s;
  logic [1:0] alu_op;

  // State register; reset drops straight back to FETCH, even mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state and Moore outputs; every output defaults to its idle value
  always_comb begin
    next_state  = FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    alu_op      = ALUOP_ADD;
    Illegal     = 1'b0;
    case (state)
      FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        pc_update  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          OP_JALR:      next_state = HAS_JALR ? JALR : ILLEGAL;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_state  = FETCH;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = 1'b1;
        next_state  = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_state  = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        retire_s   = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      JALR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        pc_update  = 1'b1;
        next_state = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        next_state  = FETCH;
      end
      ILLEGAL: begin
        Illegal    = 1'b1;
        next_state = ILLEGAL;
      end
      default: next_state = FETCH;
    endcase
  end

  // Extend-unit select straight from the opcode
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_op     (alu_op),
    .alu_control(ALUControl)
  );

  // Enables are masked while reset is high so nothing is written during reset
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign RegWrite = reg_write_s & ~reset;
  assign Retire   = retire_s    & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Randomised self-checking bench for mc_controller against a per-instruction
// cycle-table reference model.
module tb_mc_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       regw;
    logic       ret;
    logic       ill;
  } outs_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BQ   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] JR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = RT;
  logic [6:0] op2 = RT;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;

  logic       pcw_a, adr_a, memw_a, irw_a, regw_a, ret_a, ill_a;
  logic [1:0] rs_a, sa_a, sb_a, imm_a;
  logic [2:0] alu_a;
  logic       pcw_b, adr_b, memw_b, irw_b, regw_b, ret_b, ill_b;
  logic [1:0] rs_b, sa_b, sb_b, imm_b;
  logic [2:0] alu_b;
  outs_t      got_a, got_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_controller #(.HAS_JALR(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(memw_a),
    .IRWrite(irw_a), .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
    .ImmSrc(imm_a), .ALUControl(alu_a), .RegWrite(regw_a), .Retire(ret_a),
    .Illegal(ill_a)
  );

  mc_controller #(.HAS_JALR(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op(op2), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(memw_b),
    .IRWrite(irw_b), .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
    .ImmSrc(imm_b), .ALUControl(alu_b), .RegWrite(regw_b), .Retire(ret_b),
    .Illegal(ill_b)
  );

  assign got_a = {pcw_a, adr_a, memw_a, irw_a, rs_a, sa_a, sb_a, imm_a, alu_a, regw_a, ret_a, ill_a};
  assign got_b = {pcw_b, adr_b, memw_b, irw_b, rs_b, sa_b, sb_b, imm_b, alu_b, regw_b, ret_b, ill_b};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation as a function of the requested operation kind
  function automatic logic [2:0] alu_of(input int kind, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7);
    if (kind == 1) return 3'b001;
    if (kind == 2) begin
      if (f3 == 3'b000) return (f7 && o[5]) ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
    end
    return 3'b000;
  endfunction

  function automatic bit is_legal(input logic [6:0] o, input bit hj);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) ||
           (o == JL) || (o == JR && hj);
  endfunction

  function automatic int len_of(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == BQ) return 3;
    return 4;
  endfunction

  // Expected outputs in cycle k (0 = fetch cycle) of an instruction
  function automatic outs_t model(input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input int k,
                                  input bit hj);
    outs_t e;
    int kind;
    e = '0;
    kind = 0;
    e.imm = imm_of(o);
    if (k == 0) begin
      e.irw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = 1'b1;
    end else if (k == 1) begin
      e.sa = 2'b01; e.sb = 2'b01;
    end else if (!is_legal(o, hj)) begin
      e.ill = 1'b1;
    end else if (o == LW || o == SW) begin
      if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
      else if (o == SW) begin e.adr = 1'b1; e.memw = 1'b1; e.ret = 1'b1; end
      else if (k == 3) e.adr = 1'b1;
      else begin e.rs = 2'b01; e.regw = 1'b1; e.ret = 1'b1; end
    end else if (o == RT || o == IT) begin
      if (k == 2) begin e.sa = 2'b10; e.sb = (o == IT) ? 2'b01 : 2'b00; kind = 2; end
      else begin e.regw = 1'b1; e.ret = 1'b1; end
    end else if (o == BQ) begin
      e.sa = 2'b10; kind = 1; e.pcw = z; e.ret = 1'b1;
    end else if (o == JL) begin
      if (k == 2) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      else begin e.regw = 1'b1; e.ret = 1'b1; end
    end else begin
      if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; end
      else begin e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.regw = 1'b1; e.ret = 1'b1; end
    end
    e.alu = alu_of(kind, o, f3, f7);
    return e;
  endfunction

  function automatic outs_t reset_exp(input logic [6:0] o);
    outs_t e;
    e = model(o, 3'b000, 1'b0, 1'b0, 0, 1'b1);
    e.pcw = 1'b0; e.irw = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input outs_t got, input outs_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Enter at posedge+1 with the DUT in FETCH; leave the same way
  task automatic run_instr(input bit nj, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int n,
                           input string tag);
    int len;
    outs_t e;
    len = (n > 0) ? n : len_of(o);
    if (nj) op2 = o; else op = o;
    funct3 = f3;
    funct7b5 = f7;
    for (int k = 0; k < len; k++) begin
      Zero = (zmode == 2) ? 1'($urandom_range(1, 0)) : 1'(zmode);
      @(negedge clk);
      e = model(o, f3, f7, Zero, k, !nj);
      if (nj) chk($sformatf("%s_c%0d", tag, k), got_b, e);
      else    chk($sformatf("%s_c%0d", tag, k), got_a, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_a"}, got_a, reset_exp(op));
    chk({tag, "_b"}, got_b, reset_exp(op2));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [7];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT;
    ops[4] = BQ; ops[5] = JL; ops[6] = JR;

    // Reset state, then release between edges so the next edge is FETCH
    repeat (2) @(negedge clk);
    chk("reset_a", got_a, reset_exp(op));
    chk("reset_b", got_b, reset_exp(op2));
    @(posedge clk); #1;
    reset = 1'b0;

    // Build without jalr: lw works, jalr goes illegal and stays there
    run_instr(1'b1, LW, 3'b000, 1'b0, 2, 0, "nj_lw");
    run_instr(1'b1, JR, 3'b000, 1'b0, 2, 12, "nj_jalr_ill");
    do_reset("rst1");

    // Directed instructions
    run_instr(1'b0, LW, 3'b010, 1'b0, 2, 0, "lw");
    run_instr(1'b0, BQ, 3'b000, 1'b0, 1, 0, "beq_z1");
    run_instr(1'b0, BQ, 3'b000, 1'b0, 0, 0, "beq_z0");
    run_instr(1'b0, RT, 3'b000, 1'b1, 2, 0, "r_sub");
    run_instr(1'b0, RT, 3'b111, 1'b0, 2, 0, "r_and");
    run_instr(1'b0, IT, 3'b000, 1'b1, 2, 0, "i_add");
    run_instr(1'b0, SW, 3'b010, 1'b0, 2, 0, "sw");
    run_instr(1'b0, JR, 3'b000, 1'b0, 2, 0, "jalr");
    run_instr(1'b0, JL, 3'b000, 1'b0, 2, 0, "jal");

    // Random legal instruction stream
    for (int i = 0; i < 40; i++) begin
      run_instr(1'b0, ops[$urandom_range(6, 0)], 3'($urandom), 1'($urandom),
                2, 0, $sformatf("rnd%0d", i));
    end

    // Reset asserted between edges during the store's write cycle
    run_instr(1'b0, SW, 3'b010, 1'b0, 2, 3, "sw_pre");
    @(negedge clk);
    chk("sw_memwrite", got_a, model(SW, 3'b010, 1'b0, Zero, 3, 1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("sw_reset_async", got_a, reset_exp(op));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(1'b0, RT, 3'b110, 1'b0, 2, 0, "post_rst_r");

    // Unknown opcode locks up until reset
    run_instr(1'b0, 7'b0000000, 3'b000, 1'b0, 2, 12, "ill");
    do_reset("rst2");
    run_instr(1'b0, IT, 3'b010, 1'b0, 2, 0, "post_ill_i");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter HAS_JALR, default 1: 1 decodes jalr (1100111); 0 routes it to ILLEGAL.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port op, input, 7, Instr[6:0] from the instruction register.
REQ-005 SHALL have port funct3, input, 3, Instr[14:12].
REQ-006 SHALL have port funct7b5, input, 1, Instr[30].
REQ-007 SHALL have port Zero, input, 1, ALU zero flag.
REQ-008 SHALL have port PCWrite, output, 1, PC register enable.
REQ-009 SHALL have port AdrSrc, output, 1, memory address select: 0=PC, 1=Result.
REQ-010 SHALL have port MemWrite, output, 1, unified memory write enable.
REQ-011 SHALL have port IRWrite, output, 1, enables the instruction and OldPC registers.
REQ-012 SHALL have port ResultSrc, output, 2, 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 SHALL have port ALUSrcA, output, 2, 00=PC, 01=OldPC, 10=A register.
REQ-014 SHALL have port ALUSrcB, output, 2, 00=B register, 01=ImmExt, 10=constant 4.
REQ-015 SHALL have port ImmSrc, output, 2, extend-unit select, with the same encoding as the single-cycle extend unit.
REQ-016 SHALL have port ALUControl, output, 3, the single-cycle ALU encoding.
REQ-017 SHALL have port RegWrite, output, 1, register file write enable.
REQ-018 SHALL have port Retire, output, 1, high in the last cycle of each instruction.
REQ-019 SHALL have port Illegal, output, 1, high while in ILLEGAL.

Function
REQ-020 SHALL be a Moore FSM. Exceptions: PCWrite = PCUpdate | (Branch & Zero); ImmSrc and ALUControl are combinational from op/funct3/funct7b5/ALUOp.
REQ-021 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1, and go to DECODE.
REQ-022 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, 1100111->JALR, other->ILLEGAL.
REQ-023 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op[5]=0, else MEMWRITE.
REQ-024 MEMREAD: ResultSrc=00, AdrSrc=1, ->MEMWB. MEMWB: ResultSrc=01, RegWrite=1, ->FETCH. MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, ->FETCH.
REQ-025 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both ->ALUWB.
REQ-026 ALUWB SHALL drive ResultSrc=00, RegWrite=1, and go to FETCH.
REQ-027 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, and go to FETCH.
REQ-028 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, and go to ALUWB.
REQ-029 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1, ->JALRLINK. JALRLINK SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1, ->FETCH.
REQ-030 ImmSrc SHALL be: 01 for sw, 10 for beq, 11 for jal, and 00 for all other opcodes.
REQ-031 ALUOp->ALUControl SHALL be: 00 add(000), 01 sub(001), 10 by funct3 (000 add, or sub if funct7b5&op[5]; 010 slt 101; 110 or 011; 111 and 010; other 000).
REQ-032 Unlisted outputs in any state SHALL be 0, never X.
REQ-033 Latency in cycles, FETCH to the Retire cycle inclusive: lw 5, sw 4, R 4, I 4, jal 4, jalr 4, beq 3.
REQ-034 Retire SHALL be high in MEMWB, MEMWRITE, ALUWB, BEQ and JALRLINK.
REQ-035 ILLEGAL SHALL be sticky until reset, with all write enables 0 and Illegal=1.

Reset
REQ-036 Reset assertion SHALL force state to FETCH immediately, including mid-instruction.
REQ-037 While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and Retire SHALL be 0; other outputs SHALL take FETCH values.
REQ-038 The first rising edge after reset deasserts SHALL perform FETCH.

Structure
REQ-039 Package riscv_pkg SHALL hold the state enum statetype, opcode constants, and the ALUOp and ALUControl encodings.
REQ-040 ALU decode SHALL be a sub-module instance of aludec; the FSM and ImmSrc decode SHALL be in mc_controller.

Verification
REQ-041 Reset, release, op=0000011: the state sequence SHALL be FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and Retire=1 on cycle 5 only.
REQ-042 op=1100011, Zero=1: PCWrite=1 in the BEQ cycle. Repeat with Zero=0: PCWrite=0 in the BEQ cycle. Both paths SHALL be 3 cycles.
REQ-043 op=0110011, funct3=000, funct7b5=1: ALUControl=001 in EXECR. With funct3=111: ALUControl=010.
REQ-044 op=1100111 with HAS_JALR=1: JALR with PCWrite=1, ResultSrc=10, then JALRLINK with RegWrite=1. With HAS_JALR=0: Illegal=1, held for 10 cycles.
REQ-045 Reset asserted in MEMWRITE: MemWrite SHALL drop to 0 without waiting for a clock edge, and the state SHALL be FETCH.
REQ-046 op=0100011: MemWrite=1 and AdrSrc=1 for exactly one cycle, and ImmSrc=01 throughout.
